// File: rtl/mmio_tone_responder_pkg.sv
// Shared definitions for the memory-mapped tone peripheral.
//   - Register byte offsets within the 16-byte window
//   - CTRL / STAT bit positions
//   - Store / load width encodings (same encoding the data memory model uses)
//   - Playback FSM state type
`timescale 1ns/1ps
package mmio_tone_responder_pkg;

    // Register byte offsets (word aligned, decoded from addr[3:0])
    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_HPER = 4'h4;
    localparam logic [3:0] OFF_DUR  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    // CTRL bit positions
    localparam int CTRL_CONT  = 0;
    localparam int CTRL_L_EN  = 1;
    localparam int CTRL_R_EN  = 2;
    localparam int CTRL_START = 4;

    // STAT bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    // Store width encodings (write_type)
    localparam logic [1:0] WT_BYTE = 2'b00;
    localparam logic [1:0] WT_HALF = 2'b01;
    localparam logic [1:0] WT_WORD = 2'b10;

    // Load width encodings (rd_type)
    localparam logic [2:0] RT_BYTE  = 3'b000;
    localparam logic [2:0] RT_HALF  = 3'b001;
    localparam logic [2:0] RT_WORD  = 3'b010;
    localparam logic [2:0] RT_BYTEU = 3'b100;
    localparam logic [2:0] RT_HALFU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } tone_state_t;

endpackage

// File: rtl/mmio_tone_responder_counter.sv
// tone_counter: half-period counter, square-wave toggle and toggle counter.
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   clear        in   zero wave and both counters (restart / stop / completion)
//   enable       in   count while the tone is playing
//   half_period  in   CNT_W  half period in clk cycles
//   wave         out  registered square wave
//   hit          out  comb: this cycle ends a half period (a toggle happens at the edge)
//   toggles      out  CNT_W  number of toggles since the last clear (saturating)
`timescale 1ns/1ps
module tone_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] half_period,
    output logic             wave,
    output logic             hit,
    output logic [CNT_W-1:0] toggles
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;

    assign limit = half_period - ONE;

    // A ">=" test rather than "==" so that shrinking the half period mid-play
    // wraps on the next cycle instead of running the counter all the way round.
    // A zero half period toggles every cycle rather than stalling.
    assign hit = enable && ((half_period == '0) || (count >= limit));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wave    <= 1'b0;
            count   <= '0;
            toggles <= '0;
        end else if (enable) begin
            if (hit) begin
                wave  <= ~wave;
                count <= '0;
                // Saturate so a long continuous run never wraps back below DUR.
                if (toggles != '1) begin
                    toggles <= toggles + ONE;
                end
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/mmio_tone_responder.sv
// mmio_tone_responder: memory-mapped square-wave tone peripheral on the core's
// load/store data bus. The core programs half period, duration and mode with
// word stores and polls status with word loads.
//   clk         in   core clock
//   rst         in   synchronous active-high reset
//   addr        in   32  byte address
//   wr_data     in   32  store data
//   write_en    in   store strobe
//   read_en     in   load strobe
//   write_type  in   2   store width (only word stores are accepted)
//   rd_type     in   3   load width (only word loads return data)
//   sel         out  comb: address falls in this block's 16-byte window
//   out         out  32  comb read data, 0 unless a selected word load
//   sound_L     out  left square wave
//   sound_R     out  right square wave
//   busy        out  high while playing
`timescale 1ns/1ps
module mmio_tone_responder
    import mmio_tone_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          CNT_W     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [1:0]  write_type,
    input  logic [2:0]  rd_type,
    output logic        sel,
    output logic [31:0] out,
    output logic        sound_L,
    output logic        sound_R,
    output logic        busy
);

    localparam logic [CNT_W:0] ONE_X = {{CNT_W{1'b0}}, 1'b1};

    tone_state_t      state;
    logic             cont;
    logic             l_en;
    logic             r_en;
    logic [CNT_W-1:0] hper;
    logic [CNT_W-1:0] dur;
    logic             done;

    logic             wave;
    logic             hit;
    logic [CNT_W-1:0] toggles;

    logic [3:0]       reg_off;
    logic             wr_ok;
    logic             wr_ctrl;
    logic             wr_hper;
    logic             wr_dur;
    logic             wr_stat;
    logic             start_req;
    logic             stop_req;
    logic             finish;
    logic             ctr_clear;
    logic [31:0]      rd_data;
    logic             unused_bits;

    // Address decode and store qualification
    assign sel     = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_off = {addr[3:2], 2'b00};
    assign wr_ok   = write_en && sel && (write_type == WT_WORD) && (addr[1:0] == 2'b00);
    assign wr_ctrl = wr_ok && (reg_off == OFF_CTRL);
    assign wr_hper = wr_ok && (reg_off == OFF_HPER);
    assign wr_dur  = wr_ok && (reg_off == OFF_DUR);
    assign wr_stat = wr_ok && (reg_off == OFF_STAT);

    assign unused_bits = ^{wr_data[31:CNT_W], wr_data[3]};

    // START is only honoured with a non-zero half period, both from IDLE and
    // as a restart during PLAY.
    assign start_req = wr_ctrl && wr_data[CTRL_START] && (hper != '0);

    // Continuous play is stopped by a CTRL store clearing CONT without START.
    assign stop_req  = wr_ctrl && (state == PLAY) && cont &&
                       !wr_data[CTRL_CONT] && !wr_data[CTRL_START];

    // One-shot completes on the toggle that brings the count up to DUR; with
    // DUR==0 that is the very first toggle, which is then suppressed by clear.
    assign finish    = (state == PLAY) && hit && !cont &&
                       (({1'b0, toggles} + ONE_X) >= {1'b0, dur});

    assign ctr_clear = start_req || stop_req || finish;

    tone_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (ctr_clear),
        .enable      (state == PLAY),
        .half_period (hper),
        .wave        (wave),
        .hit         (hit),
        .toggles     (toggles)
    );

    // Register file and playback FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cont  <= 1'b0;
            l_en  <= 1'b0;
            r_en  <= 1'b0;
            hper  <= '0;
            dur   <= '0;
            done  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                cont <= wr_data[CTRL_CONT];
                l_en <= wr_data[CTRL_L_EN];
                r_en <= wr_data[CTRL_R_EN];
            end
            if (wr_hper) begin
                hper <= wr_data[CNT_W-1:0];
            end
            if (wr_dur) begin
                dur <= wr_data[CNT_W-1:0];
            end
            if (wr_stat && wr_data[STAT_DONE]) begin
                done <= 1'b0;
            end

            // Placed after the W1C so a completion on the same edge keeps done set.
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state <= PLAY;
                        done  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (start_req) begin
                        done <= 1'b0;
                    end else if (stop_req) begin
                        state <= IDLE;
                    end else if (finish) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are built only from registered state, never from the bus.
    assign busy    = (state == PLAY);
    assign sound_L = wave && l_en && (state == PLAY);
    assign sound_R = wave && r_en && (state == PLAY);

    // Read mux; START always reads back as 0.
    always_comb begin
        rd_data = '0;
        case (reg_off)
            OFF_CTRL: begin
                rd_data[CTRL_CONT] = cont;
                rd_data[CTRL_L_EN] = l_en;
                rd_data[CTRL_R_EN] = r_en;
            end
            OFF_HPER: rd_data[CNT_W-1:0] = hper;
            OFF_DUR:  rd_data[CNT_W-1:0] = dur;
            OFF_STAT: begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done;
            end
            default: rd_data = '0;
        endcase
    end

    assign out = (sel && read_en && (rd_type == RT_WORD)) ? rd_data : '0;

endmodule

// File: tb/tb_mmio_tone_responder.sv
// Directed testbench for mmio_tone_responder: register reset values, one-shot
// and continuous playback timing, reset mid-play, ignored stores, START with a
// zero half period, and a half-period change during playback.
`timescale 1ns/1ps
module tb_mmio_tone_responder;
    import mmio_tone_responder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        write_en;
    logic        read_en;
    logic [1:0]  write_type;
    logic [2:0]  rd_type;
    logic        sel;
    logic [31:0] out;
    logic        sound_L;
    logic        sound_R;
    logic        busy;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] v;

    // Expected wave after edge k of the START edge (bit k)
    logic [24:0] exp_t2;
    logic [12:0] exp_t3;
    logic [5:0]  exp_t6;

    always #5 clk = ~clk;

    mmio_tone_responder #(
        .BASE_ADDR(BASE),
        .CNT_W    (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wr_data    (wr_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_type (write_type),
        .rd_type    (rd_type),
        .sel        (sel),
        .out        (out),
        .sound_L    (sound_L),
        .sound_R    (sound_R),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Store sampled at the next rising edge; returns 1 ns after that edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] wt);
        @(negedge clk);
        addr       = a;
        wr_data    = d;
        write_type = wt;
        write_en   = 1'b1;
        @(posedge clk);
        #1;
        write_en   = 1'b0;
        write_type = WT_WORD;
    endtask

    // Combinational word load, completed well inside the current cycle.
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr    = a;
        rd_type = RT_WORD;
        read_en = 1'b1;
        #0.2;
        d       = out;
        read_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        addr       = '0;
        wr_data    = '0;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_type = WT_WORD;
        rd_type    = RT_WORD;
        exp_t2     = 25'b0_1111_0000_1111_0000_1111_0000;
        exp_t3     = 13'b0_111_000_111_000;
        exp_t6     = 6'b110011;   // bit0 = edge 7 ... bit5 = edge 12
        step(3);
        rst = 1'b0;
        step(1);

        // 1: reset state
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4 * i), v);
            chk($sformatf("rst_reg%0d", i), v, 32'h0);
        end
        chk("rst_sound_l", 32'(sound_L), 32'h0);
        chk("rst_sound_r", 32'(sound_R), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // 2: one-shot, HPER=4 DUR=6, both channels
        wr(BASE + 32'h4, 32'd4, WT_WORD);
        wr(BASE + 32'h8, 32'd6, WT_WORD);
        wr(BASE + 32'h0, 32'h16, WT_WORD);
        chk("t2_busy_start", 32'(busy), 32'h1);
        for (int k = 1; k <= 24; k++) begin
            step(1);
            chk($sformatf("t2_l_k%0d", k), 32'(sound_L), 32'(exp_t2[k]));
            chk($sformatf("t2_r_k%0d", k), 32'(sound_R), 32'(exp_t2[k]));
            if (k == 23) chk("t2_busy_k23", 32'(busy), 32'h1);
        end
        chk("t2_busy_end", 32'(busy), 32'h0);
        rd(BASE + 32'hC, v);
        chk("t2_stat", v, 32'h2);
        wr(BASE + 32'hC, 32'h2, WT_WORD);
        rd(BASE + 32'hC, v);
        chk("t2_stat_w1c", v, 32'h0);

        // 3: continuous, HPER=3, left only
        wr(BASE + 32'h4, 32'd3, WT_WORD);
        wr(BASE + 32'h0, 32'h13, WT_WORD);
        rd(BASE + 32'h0, v);
        chk("t3_ctrl_rb", v, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("t3_l_k%0d", k), 32'(sound_L), 32'(exp_t3[k]));
            chk($sformatf("t3_r_k%0d", k), 32'(sound_R), 32'h0);
        end
        step(38);
        chk("t3_busy_run", 32'(busy), 32'h1);
        wr(BASE + 32'h0, 32'h0, WT_WORD);
        chk("t3_busy_stop", 32'(busy), 32'h0);
        chk("t3_l_stop", 32'(sound_L), 32'h0);
        rd(BASE + 32'hC, v);
        chk("t3_stat", v, 32'h0);

        // 4: reset in the middle of a one-shot
        wr(BASE + 32'h4, 32'd10, WT_WORD);
        wr(BASE + 32'h8, 32'd100, WT_WORD);
        wr(BASE + 32'h0, 32'h16, WT_WORD);
        step(15);
        chk("t4_l_k15", 32'(sound_L), 32'h1);
        chk("t4_busy_k15", 32'(busy), 32'h1);
        rd(BASE + 32'h4, v);
        chk("t4_hper_rb", v, 32'd10);
        step(10);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_l", 32'(sound_L), 32'h0);
        chk("t4_r", 32'(sound_R), 32'h0);
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4 * i), v);
            chk($sformatf("t4_reg%0d", i), v, 32'h0);
        end

        // 5: ignored stores and out-of-window decode
        wr(BASE + 32'h4, 32'd7, WT_WORD);
        wr(BASE + 32'h4, 32'hFF, WT_BYTE);
        rd(BASE + 32'h4, v);
        chk("t5_byte_store", v, 32'd7);
        wr(BASE + 32'h5, 32'h33, WT_WORD);
        rd(BASE + 32'h4, v);
        chk("t5_misaligned", v, 32'd7);
        wr(BASE + 32'h10, 32'h16, WT_WORD);
        chk("t5_busy_oob", 32'(busy), 32'h0);
        rd(BASE + 32'h0, v);
        chk("t5_ctrl_oob", v, 32'h0);
        addr    = BASE + 32'h10;
        read_en = 1'b1;
        #0.2;
        chk("t5_sel_oob", 32'(sel), 32'h0);
        chk("t5_out_oob", out, 32'h0);
        addr = BASE + 32'h8;
        #0.2;
        chk("t5_sel_in", 32'(sel), 32'h1);
        read_en = 1'b0;

        // 6: START ignored with HPER=0, then HPER shrink during continuous play
        wr(BASE + 32'h4, 32'd0, WT_WORD);
        wr(BASE + 32'h0, 32'h16, WT_WORD);
        chk("t6_busy_hper0", 32'(busy), 32'h0);
        step(2);
        chk("t6_busy_hper0_later", 32'(busy), 32'h0);
        wr(BASE + 32'h4, 32'd8, WT_WORD);
        wr(BASE + 32'h0, 32'h13, WT_WORD);
        chk("t6_busy_start", 32'(busy), 32'h1);
        step(5);
        chk("t6_l_k5", 32'(sound_L), 32'h0);
        wr(BASE + 32'h4, 32'd2, WT_WORD);   // sampled while count is 5
        chk("t6_l_k6", 32'(sound_L), 32'h0);
        for (int k = 7; k <= 12; k++) begin
            step(1);
            chk($sformatf("t6_l_k%0d", k), 32'(sound_L), 32'(exp_t6[k - 7]));
        end
        rd(BASE + 32'h4, v);
        chk("t6_hper_rb", v, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
